// File: rtl/tempsens_pkg.sv
// Shared types and constants for the temperature-sensor conversion sequencer.
package tempsens_pkg;

    localparam int unsigned DoutWDefault = 24;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        CONV,
        CAPT,
        DONE
    } tempsens_state_e;

endpackage

// File: rtl/tempsens_seq_if.sv
// Sensor-side handshake: counter reset, enable, DONE strobe and count bus.
interface tempsens_seq_if
    import tempsens_pkg::*;
#(
    parameter int unsigned DoutW = DoutWDefault
) ();

    logic             sensor_rst_no;
    logic             sensor_en_o;
    logic             sensor_done_i;
    logic [DoutW-1:0] sensor_dout_i;

    modport master (
        output sensor_rst_no,
        output sensor_en_o,
        input  sensor_done_i,
        input  sensor_dout_i
    );

    modport slave (
        input  sensor_rst_no,
        input  sensor_en_o,
        output sensor_done_i,
        output sensor_dout_i
    );

endinterface

// File: rtl/tempsens_sync.sv
// Two-flop synchronizer for the sensor DONE strobe, async reset to 0.
module tempsens_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/tempsens_seq.sv
// Sequencer running NumAvg sensor conversions per batch and averaging the counts.
// Optional per-phase watchdog: define TEMPSENS_SEQ_TIMEOUT_EN.
module tempsens_seq
    import tempsens_pkg::*;
#(
    parameter int unsigned NumAvg        = 4,
    parameter int unsigned DoutW         = DoutWDefault,
    parameter int unsigned RstCycles     = 4,
    parameter int unsigned TimeoutCycles = 65535
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    tempsens_seq_if.master   sens,
    output logic             busy_o,
    output logic [DoutW-1:0] result_o,
    output logic             result_valid_o,
    output logic             timeout_o
);

    localparam int unsigned AvgShift = $clog2(NumAvg);
    localparam int unsigned AccW     = DoutW + AvgShift;
    localparam int unsigned CntW     = $clog2(NumAvg + 1);
    localparam int unsigned RstCntW  = $clog2(RstCycles + 1);

    if (NumAvg < 1 || NumAvg > 16 || (NumAvg & (NumAvg - 1)) != 0 ||
        RstCycles < 1 || TimeoutCycles < 1) begin : g_param_check
        $error("tempsens_seq: illegal parameter set");
    end

    tempsens_state_e      state_q, state_d;
    logic                 done_s;
    logic [RstCntW-1:0]   rst_cnt_q;
    logic                 rst_done;
    logic [AccW-1:0]      acc_q;
    logic [CntW-1:0]      cnt_q;
    logic                 last_sample;
    logic                 wd_hit;

    tempsens_sync u_done_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (sens.sensor_done_i),
        .q_o   (done_s)
    );

    assign rst_done    = (rst_cnt_q == RstCntW'(RstCycles - 1));
    assign last_sample = (cnt_q == CntW'(NumAvg - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // A DONE still high from the previous conversion holds the sequencer in RST.
    always_comb begin
        state_d = state_q;
        if (abort_i || wd_hit) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start_i) state_d = RST;
                RST:     if (rst_done && !done_s) state_d = CONV;
                CONV:    if (done_s) state_d = CAPT;
                CAPT:    state_d = last_sample ? DONE : RST;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o             = (state_q != IDLE);
        sens.sensor_en_o   = (state_q inside {CONV, CAPT});
        sens.sensor_rst_no = (state_q inside {CONV, CAPT});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_cnt_q <= '0;
        end else if (state_q != RST) begin
            rst_cnt_q <= '0;
        end else if (!rst_done) begin
            rst_cnt_q <= rst_cnt_q + RstCntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q          <= '0;
            cnt_q          <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
        end else begin
            result_valid_o <= (state_q == DONE) && !abort_i;
            if (state_q == DONE && !abort_i) begin
                result_o <= DoutW'(acc_q >> AvgShift);
            end
            if (abort_i || wd_hit || state_q == DONE) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (state_q == CAPT) begin
                acc_q <= acc_q + AccW'(sens.sensor_dout_i);
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

`ifdef TEMPSENS_SEQ_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TimeoutCycles + 1);

    logic [WdW-1:0] wd_cnt_q;
    logic           timeout_q;

    assign wd_hit    = (state_q inside {RST, CONV}) && (wd_cnt_q == WdW'(TimeoutCycles - 1));
    assign timeout_o = timeout_q;

    // Restarts on every phase entry, so each RST/CONV gets its own budget.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_q inside {RST, CONV}) && state_d == state_q) wd_cnt_q <= wd_cnt_q + WdW'(1);
            else                                                     wd_cnt_q <= '0;
            if (wd_hit && !abort_i)                             timeout_q <= 1'b1;
            else if (state_q == IDLE && start_i && !abort_i)    timeout_q <= 1'b0;
        end
    end
`else
    assign wd_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_tempsens_seq.sv
// Directed bench: averaging instance (NumAvg=4) and pass-through instance (NumAvg=1).
module tb_tempsens_seq;

    logic        clk;
    logic        rst_n;
    logic        a_start, b_start, abort;
    logic        done;
    logic [23:0] dout;

    logic        a_busy, a_valid, a_tmo;
    logic        b_busy, b_valid, b_tmo;
    logic [23:0] a_res, b_res;

    int total = 0;
    int bad   = 0;

    tempsens_seq_if #(.DoutW(24)) a_if ();
    tempsens_seq_if #(.DoutW(24)) b_if ();

    assign a_if.sensor_done_i = done;
    assign a_if.sensor_dout_i = dout;
    assign b_if.sensor_done_i = done;
    assign b_if.sensor_dout_i = dout;

    tempsens_seq #(.NumAvg(4), .DoutW(24), .RstCycles(4), .TimeoutCycles(100)) u_avg (
        .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .abort_i(abort), .sens(a_if),
        .busy_o(a_busy), .result_o(a_res), .result_valid_o(a_valid), .timeout_o(a_tmo)
    );

    tempsens_seq #(.NumAvg(1), .DoutW(24), .RstCycles(4), .TimeoutCycles(100)) u_pass (
        .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .abort_i(abort), .sens(b_if),
        .busy_o(b_busy), .result_o(b_res), .result_valid_o(b_valid), .timeout_o(b_tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: observed=running expected=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic en_of(input int sel);
        return (sel == 0) ? a_if.sensor_en_o : b_if.sensor_en_o;
    endfunction

    task automatic wait_en(input int sel, input logic lvl, input string tag);
        int n = 0;
        while (en_of(sel) !== lvl && n < 400) begin
            tick();
            n++;
        end
        chk(tag, 32'(en_of(sel)), 32'(lvl));
    endtask

    task automatic convert(input int sel, input logic [23:0] d, input int hold, input string tag);
        wait_en(sel, 1'b1, {tag, "_en_rise"});
        dout = d;
        done = 1'b1;
        wait_en(sel, 1'b0, {tag, "_en_fall"});
        repeat (hold) tick();
        done = 1'b0;
    endtask

    task automatic collect(input int sel, output int pulses, output logic [23:0] res);
        pulses = 0;
        res    = '0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ((sel == 0) ? a_valid : b_valid) begin
                pulses++;
                res = (sel == 0) ? a_res : b_res;
            end
            if (!((sel == 0) ? a_busy : b_busy)) break;
        end
        tick();
        if ((sel == 0) ? a_valid : b_valid) pulses++;
    endtask

    initial begin
        int          n;
        int          pulses;
        logic [23:0] res;

        rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0; abort = 1'b0;
        done  = 1'b0; dout = '0;
        tick(); tick();
        chk("rst_a_busy",   32'(a_busy), 0);
        chk("rst_a_result", 32'(a_res), 0);
        chk("rst_a_valid",  32'(a_valid), 0);
        chk("rst_a_tmo",    32'(a_tmo), 0);
        chk("rst_a_en",     32'(a_if.sensor_en_o), 0);
        chk("rst_a_rstn",   32'(a_if.sensor_rst_no), 0);
        rst_n = 1'b1;
        tick();

        // Pass-through: 4-cycle counter reset, DOUT returned unchanged
        chk("b_busy_before", 32'(b_busy), 0);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b_busy_rise", 32'(b_busy), 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (b_if.sensor_en_o) break;
            if (!b_if.sensor_rst_no && b_busy) n++;
            tick();
        end
        chk("b_rst_low_cycles", 32'(n), 4);
        chk("b_rst_release", 32'(b_if.sensor_rst_no), 1);
        dout = 24'hABCDEF;
        done = 1'b1;
        wait_en(1, 1'b0, "b_en_fall");
        done = 1'b0;
        collect(1, pulses, res);
        chk("b_result", 32'(res), 32'hABCDEF);
        chk("b_pulses", 32'(pulses), 1);
        chk("b_result_held", 32'(b_res), 32'hABCDEF);

        // Averaging of four samples
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        convert(0, 24'h000100, 0, "avg0");
        convert(0, 24'h000102, 0, "avg1");
        convert(0, 24'h000104, 0, "avg2");
        convert(0, 24'h000106, 0, "avg3");
        collect(0, pulses, res);
        chk("avg_result", 32'(res), 32'h000103);
        chk("avg_pulses", 32'(pulses), 1);
        chk("avg_idle", 32'(a_busy), 0);

        // Stale DONE held across RST blocks CONV until it falls
        dout = '0;
        done = 1'b1;
        repeat (3) tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (a_if.sensor_en_o) n++;
        end
        chk("stale_no_conv", 32'(n), 0);
        chk("stale_busy", 32'(a_busy), 1);
        done = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (a_if.sensor_en_o) break;
        end
        chk("stale_release_lat", 32'(n), 3);
        convert(0, 24'd10, 6, "st0");
        convert(0, 24'd20, 0, "st1");
        convert(0, 24'd30, 0, "st2");
        convert(0, 24'd40, 0, "st3");
        collect(0, pulses, res);
        chk("stale_result", 32'(res), 32'd25);
        chk("stale_pulses", 32'(pulses), 1);

        // Start while busy ignored; abort beats start; abort clears the sum
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        convert(0, 24'd1000, 0, "ab0");
        wait_en(0, 1'b1, "ab_conv");
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("busy_start_ignored", 32'(a_if.sensor_en_o), 1);
        abort = 1'b1; a_start = 1'b1;
        tick();
        abort = 1'b0; a_start = 1'b0;
        chk("abort_busy", 32'(a_busy), 0);
        chk("abort_en",   32'(a_if.sensor_en_o), 0);
        chk("abort_rstn", 32'(a_if.sensor_rst_no), 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (a_valid) n++;
            tick();
        end
        chk("abort_no_valid", 32'(n), 0);
        chk("abort_result_kept", 32'(a_res), 32'd25);
        abort = 1'b1; a_start = 1'b1;
        tick();
        abort = 1'b0; a_start = 1'b0;
        chk("idle_abort_prio", 32'(a_busy), 0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 4; i++) convert(0, 24'd8, 0, "post_abort");
        collect(0, pulses, res);
        chk("post_abort_result", 32'(res), 32'd8);

        // Reset mid-batch after two samples
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        convert(0, 24'h800000, 0, "mid0");
        convert(0, 24'h800000, 0, "mid1");
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   32'(a_busy), 0);
        chk("mid_rst_en",     32'(a_if.sensor_en_o), 0);
        chk("mid_rst_rstn",   32'(a_if.sensor_rst_no), 0);
        chk("mid_rst_result", 32'(a_res), 0);
        chk("mid_rst_valid",  32'(a_valid), 0);
        chk("mid_rst_tmo",    32'(a_tmo), 0);
        chk("mid_rst_b_res",  32'(b_res), 0);
        tick();
        rst_n = 1'b1;
        dout = 24'hFFFFFF;
        done = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_busy || a_valid) n++;
        end
        chk("mid_rst_no_accept", 32'(n), 0);
        done = 1'b0;
        repeat (3) tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        convert(0, 24'h10, 0, "new0");
        convert(0, 24'h10, 0, "new1");
        convert(0, 24'h20, 0, "new2");
        convert(0, 24'h20, 0, "new3");
        collect(0, pulses, res);
        chk("mid_rst_new_result", 32'(res), 32'h18);
        chk("mid_rst_new_pulses", 32'(pulses), 1);

`ifdef TEMPSENS_SEQ_TIMEOUT_EN
        // Watchdog: DONE never arrives, CONV abandoned after 100 cycles
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        wait_en(1, 1'b1, "tmo_conv");
        n = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (b_if.sensor_en_o) n++;
            if (!b_busy) break;
        end
        chk("tmo_conv_cycles", 32'(n), 100);
        chk("tmo_flag", 32'(b_tmo), 1);
        chk("tmo_busy", 32'(b_busy), 0);
        chk("tmo_no_valid", 32'(b_valid), 0);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("tmo_cleared", 32'(b_tmo), 0);
        chk("tmo_restart_busy", 32'(b_busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`else
        // No watchdog: CONV waits indefinitely
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        repeat (150) tick();
        chk("nowd_busy", 32'(b_busy), 1);
        chk("nowd_en",   32'(b_if.sensor_en_o), 1);
        chk("nowd_tmo",  32'(b_tmo), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("nowd_abort_idle", 32'(b_busy), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
